// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the RV32I multicycle control sequencer:
// state encoding, RV32I major opcodes, PC/writeback select codes,
// sticky error codes and the one-hot instruction class record.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_IMEM_TMO = 2'b10,
    ERR_DMEM_TMO = 2'b11
  } err_t;

  // RV32I major opcodes (IR[6:0]) handled by this core
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // pc_sel codes
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // wb_sel codes
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // ALU operand selects
  localparam logic SEL_A_RS1 = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;
  localparam logic SEL_B_RS2 = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // One-hot instruction class; exactly one bit set by the decoder
  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath /
// memories.
//  master : the sequencer (consumes opcode/br_taken/ready, drives controls)
//  slave  : the datapath/memory side
//  opcode[6:0], br_taken, imem_ready, dmem_ready   -> sequencer
//  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel[1:0],
//  alu_a_sel, alu_b_sel, reg_write, wb_sel[1:0], retire,
//  err[1:0], state_o[2:0]                           <- sequencer
interface multicycle_ctrl_fsm_if;
  logic [6:0] opcode;
  logic       br_taken;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       retire;
  logic [1:0] err;
  logic [2:0] state_o;

  modport master (
    input  opcode, br_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel,
           alu_a_sel, alu_b_sel, reg_write, wb_sel, retire, err, state_o
  );

  modport slave (
    output opcode, br_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel,
           alu_a_sel, alu_b_sel, reg_write, wb_sel, retire, err, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_instr_class_decode.sv
// Combinational opcode classifier for the multicycle sequencer.
//  opcode[6:0] in  : IR[6:0]
//  cls         out : one-hot {r,i,load,store,branch,jal,jalr,illegal};
//                    any opcode not recognised is classed illegal
module instr_class_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.r       = 1'b1;
      OP_I:      cls.i       = 1'b1;
      OP_LOAD:   cls.load    = 1'b1;
      OP_STORE:  cls.store   = 1'b1;
      OP_BRANCH: cls.branch  = 1'b1;
      OP_JAL:    cls.jal     = 1'b1;
      OP_JALR:   cls.jalr    = 1'b1;
      default:   cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer for the RV32I core. Steps one instruction
// at a time through FETCH/DECODE/EXEC/MEM/WB and drives the datapath
// enables/selects plus the imem/dmem request handshakes.
//  clk, rst : single clock; synchronous active-high reset
//  bus      : multicycle_ctrl_fsm_if.master (opcode, br_taken, readies in;
//             requests, enables, selects, retire, err, state_o out)
//  MEM_TIMEOUT : max wait cycles on imem/dmem ready; 0 waits forever
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_fsm_if.master bus
);

  // Counter width derived from the limit; kept at least 1 bit so the
  // wait-forever configuration still elaborates.
  localparam int unsigned TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);

  state_t        state;
  instr_class_t  class_q;
  instr_class_t  dec_class;
  logic [TW-1:0] tmo_cnt;
  err_t          err_q;
  logic          tmo_limit;

  instr_class_decode u_decode (
    .opcode (bus.opcode),
    .cls    (dec_class)
  );

  always_comb tmo_limit = TMO_EN && (tmo_cnt == TMO_LAST);

  // tmo_cnt is cleared on every transition out of a wait state, so it is
  // already zero whenever FETCH or MEM is entered. A ready on the limit
  // cycle is tested first and therefore wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      class_q <= '0;
      tmo_cnt <= '0;
      err_q   <= ERR_NONE;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            state   <= ST_DECODE;
            tmo_cnt <= '0;
          end else if (tmo_limit) begin
            state   <= ST_HALT;
            err_q   <= ERR_IMEM_TMO;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ST_DECODE: begin
          class_q <= dec_class;
          if (dec_class.illegal) begin
            state <= ST_HALT;
            err_q <= ERR_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (class_q.load || class_q.store) begin
            state <= ST_MEM;
          end else if (class_q.r || class_q.i) begin
            state <= ST_WB;
          end else if (class_q.branch || class_q.jal || class_q.jalr) begin
            state <= ST_FETCH;
          end else begin
            // No valid class latched: unreachable after DECODE screening
            state <= ST_HALT;
            err_q <= ERR_ILLEGAL;
          end
        end

        ST_MEM: begin
          if (bus.dmem_ready) begin
            state   <= class_q.load ? ST_WB : ST_FETCH;
            tmo_cnt <= '0;
          end else if (tmo_limit) begin
            state   <= ST_HALT;
            err_q   <= ERR_DMEM_TMO;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ST_WB:   state <= ST_FETCH;

        ST_HALT: state <= ST_HALT;

        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs are decoded from state/class_q rather than registered because
  // ir_write, the store retire and the branch pc_sel must react to
  // imem_ready/dmem_ready/br_taken in the same cycle.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = PC_PLUS4;
    bus.alu_a_sel = SEL_A_RS1;
    bus.alu_b_sel = SEL_B_RS2;
    bus.reg_write = 1'b0;
    bus.wb_sel    = WB_ALU;
    bus.retire    = 1'b0;
    bus.err       = '0;
    bus.state_o   = '0;

    if (!rst) begin
      bus.err     = err_q;
      bus.state_o = state;
      case (state)
        ST_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_write = bus.imem_ready;
        end

        ST_EXEC: begin
          if (class_q.i || class_q.load || class_q.store || class_q.jalr)
            bus.alu_b_sel = SEL_B_IMM;
          if (class_q.branch) begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = bus.br_taken ? PC_IMM : PC_PLUS4;
            bus.retire   = 1'b1;
          end
          if (class_q.jal) begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = WB_PC4;
            bus.pc_write  = 1'b1;
            bus.pc_sel    = PC_IMM;
            bus.retire    = 1'b1;
          end
          if (class_q.jalr) begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = WB_PC4;
            bus.pc_write  = 1'b1;
            bus.pc_sel    = PC_ALU;
            bus.retire    = 1'b1;
          end
        end

        ST_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = class_q.store;
          if (class_q.store && bus.dmem_ready) begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = PC_PLUS4;
            bus.retire   = 1'b1;
          end
        end

        ST_WB: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = class_q.load ? WB_MEM : WB_ALU;
          bus.pc_write  = 1'b1;
          bus.pc_sel    = PC_PLUS4;
          bus.retire    = 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. A reference model expands
// each instruction (class, memory wait counts, branch outcome) into the
// per-cycle output trace the sequencer must produce, and separately
// predicts the retire latency from the per-class cycle counts.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst4 = 1'b1;
  logic [6:0] opcode = '0;
  logic       br_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus ();
  multicycle_ctrl_fsm_if bus4 ();

  assign bus.opcode      = opcode;
  assign bus.br_taken    = br_taken;
  assign bus.imem_ready  = imem_ready;
  assign bus.dmem_ready  = dmem_ready;
  assign bus4.opcode     = opcode;
  assign bus4.br_taken   = br_taken;
  assign bus4.imem_ready = imem_ready;
  assign bus4.dmem_ready = dmem_ready;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire;
    logic [1:0] err;
    logic [2:0] state;
  } outv_t;

  typedef struct {
    logic [6:0] opc;
    logic       ir;
    logic       dr;
    logic       bt;
    outv_t      exp;
    string      tag;
  } step_t;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

  step_t q[$];
  int    lat_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ropc();
    return 7'($urandom);
  endfunction

  function automatic logic [6:0] opc_of(input kind_t k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic outv_t get_out(input bit which);
    if (which)
      return {bus4.imem_req, bus4.dmem_req, bus4.dmem_we, bus4.ir_write, bus4.pc_write,
              bus4.pc_sel, bus4.alu_a_sel, bus4.alu_b_sel, bus4.reg_write, bus4.wb_sel,
              bus4.retire, bus4.err, bus4.state_o};
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.pc_write,
            bus.pc_sel, bus.alu_a_sel, bus.alu_b_sel, bus.reg_write, bus.wb_sel,
            bus.retire, bus.err, bus.state_o};
  endfunction

  function automatic void push(input logic [6:0] opc, input logic ir, input logic dr,
                               input logic bt, input outv_t e, input string tag);
    step_t s;
    s = '{opc, ir, dr, bt, e, tag};
    q.push_back(s);
  endfunction

  function automatic outv_t o_fetch(input logic rdy);
    outv_t e = '0;
    e.imem_req = 1'b1;
    e.ir_write = rdy;
    e.state    = 3'd0;
    return e;
  endfunction

  function automatic outv_t o_halt(input logic [1:0] err);
    outv_t e = '0;
    e.state = 3'd7;
    e.err   = err;
    return e;
  endfunction

  function automatic outv_t o_mem(input logic store, input logic done);
    outv_t e = '0;
    e.state    = 3'd3;
    e.dmem_req = 1'b1;
    e.dmem_we  = store;
    e.pc_write = store & done;
    e.retire   = store & done;
    return e;
  endfunction

  // Expand one instruction into its expected cycle trace. fw/dw are the
  // number of cycles the imem/dmem hold ready low before completing.
  function automatic void build_instr(input kind_t k, input logic [6:0] op,
                                      input int fw, input int dw, input logic bt);
    outv_t e;
    bit    is_mem = (k == K_LD) || (k == K_ST);
    int    base;
    for (int c = 0; c <= fw; c++)
      push(ropc(), 1'(c == fw), rbit(), rbit(), o_fetch(1'(c == fw)), "fetch");
    e = '0;
    e.state = 3'd1;
    push(op, rbit(), rbit(), rbit(), e, "decode");
    if (k == K_ILL) begin
      for (int c = 0; c < 3; c++)
        push(ropc(), rbit(), rbit(), rbit(), o_halt(2'b01), "halt_illegal");
      return;
    end
    e = '0;
    e.state = 3'd2;
    case (k)
      K_I, K_LD, K_ST: e.alu_b_sel = 1'b1;
      K_BR: begin
        e.pc_write = 1'b1;
        e.pc_sel   = bt ? 2'b01 : 2'b00;
        e.retire   = 1'b1;
      end
      K_JAL: begin
        e.reg_write = 1'b1;
        e.wb_sel    = 2'b10;
        e.pc_write  = 1'b1;
        e.pc_sel    = 2'b01;
        e.retire    = 1'b1;
      end
      K_JALR: begin
        e.alu_b_sel = 1'b1;
        e.reg_write = 1'b1;
        e.wb_sel    = 2'b10;
        e.pc_write  = 1'b1;
        e.pc_sel    = 2'b10;
        e.retire    = 1'b1;
      end
      default: ;
    endcase
    push(op, rbit(), rbit(), (k == K_BR) ? bt : rbit(), e, "exec");
    if (is_mem) begin
      for (int c = 0; c <= dw; c++)
        push(op, rbit(), 1'(c == dw), rbit(), o_mem(1'(k == K_ST), 1'(c == dw)), "mem");
    end
    if (k == K_R || k == K_I || k == K_LD) begin
      e = '0;
      e.state     = 3'd4;
      e.reg_write = 1'b1;
      e.wb_sel    = (k == K_LD) ? 2'b01 : 2'b00;
      e.pc_write  = 1'b1;
      e.retire    = 1'b1;
      push(op, rbit(), rbit(), rbit(), e, "wb");
    end
    case (k)
      K_R, K_I, K_ST: base = 4;
      K_LD:           base = 5;
      default:        base = 3;
    endcase
    lat_q.push_back(base + fw + (is_mem ? dw : 0));
  endfunction

  task automatic apply_reset(input bit which, input int n);
    outv_t got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which) rst4 = 1'b1; else rst = 1'b1;
      opcode = ropc(); imem_ready = rbit(); dmem_ready = rbit(); br_taken = rbit();
      #1;
      got = get_out(which);
      checks++;
      if (got !== outv_t'('0)) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected %h", got, outv_t'('0));
      end
    end
  endtask

  task automatic run_steps(input bit which, input int n, input bit check_lat);
    step_t s;
    outv_t got;
    int    cyc = 0;
    int    el;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(negedge clk);
      if (which) rst4 = 1'b0; else rst = 1'b0;
      opcode = s.opc; imem_ready = s.ir; dmem_ready = s.dr; br_taken = s.bt;
      #1;
      got = get_out(which);
      cyc++;
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", s.tag, got, s.exp);
      end
      if (got.retire === 1'b1) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL latency: retire after %0d cycles, expected no retire", cyc);
        end else begin
          el = lat_q.pop_front();
          if (cyc !== el) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, el);
          end
        end
        cyc = 0;
      end
    end
    q.delete();
    if (check_lat) begin
      checks++;
      if (lat_q.size() != 0) begin
        errors++;
        $display("FAIL retire_count: %0d retires missing, expected 0", lat_q.size());
      end
    end
    lat_q.delete();
  endtask

  task automatic run_all(input bit which);
    run_steps(which, q.size(), 1'b1);
  endtask

  task automatic test_reset();
    apply_reset(0, 3);
    push(ropc(), 1'b0, rbit(), rbit(), o_fetch(1'b0), "first_fetch");
    run_all(0);
  endtask

  task automatic test_alu();
    apply_reset(0, 1);
    build_instr(K_R, opc_of(K_R), 0, 0, 1'b0);
    build_instr(K_I, opc_of(K_I), 2, 0, 1'b0);
    run_all(0);
  endtask

  task automatic test_mem();
    apply_reset(0, 1);
    build_instr(K_LD, opc_of(K_LD), 0, 3, 1'b0);
    build_instr(K_ST, opc_of(K_ST), 1, 2, 1'b0);
    build_instr(K_ST, opc_of(K_ST), 0, 0, 1'b0);
    run_all(0);
  endtask

  task automatic test_branch_jump();
    apply_reset(0, 1);
    build_instr(K_BR, opc_of(K_BR), 0, 0, 1'b1);
    build_instr(K_BR, opc_of(K_BR), 0, 0, 1'b0);
    build_instr(K_JAL, opc_of(K_JAL), 1, 0, 1'b0);
    build_instr(K_JALR, opc_of(K_JALR), 0, 0, 1'b0);
    run_all(0);
  endtask

  task automatic test_illegal();
    logic [6:0] ill [4];
    ill[0] = 7'b0000000; ill[1] = 7'b0110111; ill[2] = 7'b1110011; ill[3] = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      apply_reset(0, 1);
      build_instr(K_ILL, ill[i], i % 2, 0, 1'b0);
      run_all(0);
    end
    // HALT exits only through reset; first cycle afterwards is FETCH
    apply_reset(0, 1);
    build_instr(K_JALR, opc_of(K_JALR), 0, 0, 1'b0);
    run_all(0);
  endtask

  task automatic test_mid_reset();
    apply_reset(0, 1);
    build_instr(K_LD, opc_of(K_LD), 1, 3, 1'b0);
    run_steps(0, 5, 1'b0);
    apply_reset(0, 1);
    build_instr(K_ST, opc_of(K_ST), 0, 0, 1'b0);
    run_all(0);
  endtask

  task automatic test_timeout();
    outv_t e;
    // limit 4: imem never ready
    apply_reset(1, 2);
    for (int c = 0; c < 4; c++) push(ropc(), 1'b0, rbit(), rbit(), o_fetch(1'b0), "imem_wait");
    for (int c = 0; c < 2; c++) push(ropc(), rbit(), rbit(), rbit(), o_halt(2'b10), "halt_imem_tmo");
    run_all(1);
    // limit 4: ready on the last allowed cycle, then dmem never ready
    apply_reset(1, 1);
    for (int c = 0; c < 4; c++) push(ropc(), 1'(c == 3), 1'b0, rbit(), o_fetch(1'(c == 3)), "imem_limit");
    e = '0; e.state = 3'd1;
    push(opc_of(K_LD), rbit(), 1'b0, rbit(), e, "decode");
    e = '0; e.state = 3'd2; e.alu_b_sel = 1'b1;
    push(opc_of(K_LD), rbit(), 1'b0, rbit(), e, "exec");
    for (int c = 0; c < 4; c++) push(opc_of(K_LD), rbit(), 1'b0, rbit(), o_mem(1'b0, 1'b0), "dmem_wait");
    for (int c = 0; c < 2; c++) push(ropc(), rbit(), rbit(), rbit(), o_halt(2'b11), "halt_dmem_tmo");
    run_all(1);
    // default limit 16 on the main instance
    apply_reset(0, 1);
    for (int c = 0; c < 16; c++) push(ropc(), 1'b0, rbit(), rbit(), o_fetch(1'b0), "imem_wait16");
    push(ropc(), rbit(), rbit(), rbit(), o_halt(2'b10), "halt_imem_tmo16");
    run_all(0);
    // limit 16: store completing on its 16th MEM cycle is not a timeout
    apply_reset(0, 1);
    build_instr(K_ST, opc_of(K_ST), 15, 15, 1'b0);
    run_all(0);
  endtask

  task automatic test_back_to_back();
    kind_t k;
    apply_reset(0, 1);
    for (int i = 0; i < 24; i++) begin
      k = kind_t'($urandom_range(0, 6));
      build_instr(k, opc_of(k), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end
    run_all(0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_mid_reset();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
